// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: pointer-width helper,
// read-mode encoding and legal depth range.
package fifo_pkg;

   typedef enum logic {
      FIFO_REG  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   localparam int FIFO_DP_MIN = 2;
   localparam int FIFO_DP_MAX = 256;

   function automatic int fifo_aw(input int dp);
      return (dp <= 2) ? 1 : $clog2(dp);
   endfunction

endpackage

// File: rtl/sync_fifo_wm_if.sv
// Write/read handshake bundle between a FIFO (slave) and its user (master).
interface sync_fifo_wm_if #(
   parameter int WD = 8
) ();

   logic          wr_en;
   logic [WD-1:0] wr_data;
   logic          rd_en;
   logic [WD-1:0] rd_data;
   logic          rd_valid;
   logic          full;
   logic          empty;

   modport master (
      output wr_en, wr_data, rd_en,
      input  rd_data, rd_valid, full, empty
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
      output rd_data, rd_valid, full, empty
   );

endinterface

// File: rtl/sync_fifo_ram.sv
// DP x WD storage with a clocked write port and an asynchronous read port,
// kept separate so a foundry macro can replace it.
module sync_fifo_ram #(
   parameter int WD = 8,
   parameter int DP = 4,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [WD-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [WD-1:0] rdata
);

   logic [WD-1:0] mem [DP];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_wm.sv
// Synchronous FIFO with occupancy, programmable watermarks, show-ahead or
// registered read data, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_wm
   import fifo_pkg::*;
#(
   parameter int WD   = 8,
   parameter int DP   = 4,
   parameter int FWFT = 1,
   parameter int AW   = fifo_aw(DP)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   sync_fifo_wm_if.slave bus,
   input  logic [AW:0]   afull_th,
   input  logic [AW:0]   aempty_th,
   output logic          afull,
   output logic          aempty,
   output logic [AW:0]   occupancy,
   output logic          err_ovf,
   output logic          err_udf,
   input  logic          err_clr
);

   localparam fifo_mode_e  MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_REG;
   localparam logic [AW:0] DP_W = (AW+1)'(DP);

   if ((DP < FIFO_DP_MIN) || (DP > FIFO_DP_MAX) || ((DP & (DP - 1)) != 0) ||
       (AW != fifo_aw(DP))) begin : g_bad_dp
      $error("sync_fifo_wm: DP must be a power of 2 in 2..256 and AW left at its default");
   end

   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   occ_q;
   logic          ovf_q;
   logic          udf_q;
   logic          empty_w;
   logic          full_w;
   logic          rd_ok;
   logic          wr_ok;
   logic          ram_we;
   logic [WD-1:0] ram_rdata;

   // Acceptance is decided purely from registered occupancy, so no flag
   // depends combinationally on wr_en/rd_en.
   assign empty_w = (occ_q == '0);
   assign full_w  = (occ_q == DP_W);
   assign rd_ok   = bus.rd_en & ~empty_w;
   assign wr_ok   = bus.wr_en & (~full_w | rd_ok);
   assign ram_we  = wr_ok & reset_n & ~flush;

   sync_fifo_ram #(
      .WD (WD),
      .DP (DP),
      .AW (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr_q),
      .wdata (bus.wr_data),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + AW'(wr_ok);
         rd_ptr_q <= rd_ptr_q + AW'(rd_ok);
         occ_q    <= occ_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
         ovf_q    <= (bus.wr_en & ~wr_ok) | (ovf_q & ~err_clr);
         udf_q    <= (bus.rd_en & ~rd_ok) | (udf_q & ~err_clr);
      end
   end

   assign occupancy = occ_q;
   assign bus.empty = empty_w;
   assign bus.full  = full_w;
   assign afull     = (occ_q >= afull_th);
   assign aempty    = (occ_q <= aempty_th);
   assign err_ovf   = ovf_q;
   assign err_udf   = udf_q;

   if (MODE == FIFO_FWFT) begin : g_fwft
      assign bus.rd_data  = ram_rdata;
      assign bus.rd_valid = ~empty_w;
   end else begin : g_reg
      logic [WD-1:0] rd_data_p1;
      logic          vld_p1;

      // Stage p1: registered read word, valid for exactly one cycle per read.
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
         end else if (flush) begin
            vld_p1     <= 1'b0;
         end else begin
            vld_p1 <= rd_ok;
            if (rd_ok) begin
               rd_data_p1 <= ram_rdata;
            end
         end
      end

      assign bus.rd_data  = rd_data_p1;
      assign bus.rd_valid = vld_p1;
   end

endmodule
